// File: rtl/context_switch_unit.sv
// Context switch engine: saves the outgoing process's register file and PC into an
// on-chip context table, restores the incoming one, and hands the PC to fetch.
module context_switch_unit #(
  parameter int unsigned NUM_PROC        = 5,
  parameter int unsigned NUM_REGS        = 32,
  parameter logic [31:0] START_PC_BASE   = 32'h0,
  parameter logic [31:0] START_PC_STRIDE = 32'h100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        switch_req,
  input  logic [31:0] next_pid,
  input  logic [31:0] cur_pc,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        cpu_stall,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic [31:0] active_pid,
  output logic        switch_done,
  output logic        err_bad_pid,
  output logic        req_dropped
);

  localparam int unsigned SLOT_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE, S_LOAD_PC} state_t;

  state_t              r_state, w_next_state;
  logic [4:0]          r_k;
  logic                r_stall;
  logic                r_active_valid;
  logic [31:0]         r_active_pid;
  logic [SLOT_W-1:0]   r_active_slot;
  logic [31:0]         r_next_pid;
  logic [SLOT_W-1:0]   r_next_slot;
  logic [31:0]         r_cur_pc;
  logic [31:0]         r_ctx    [NUM_PROC][NUM_REGS];
  logic [31:0]         r_ctx_pc [NUM_PROC];
  logic                r_err;
  logic                r_same_done;
  logic                r_dropped;

  logic                w_bad;
  logic                w_same;
  logic                w_last;
  logic                w_idle_req;
  logic                w_seq_done;

  assign w_bad      = next_pid >= 32'(NUM_PROC);
  assign w_same     = r_active_valid && (next_pid == r_active_pid);
  assign w_last     = (r_k == 5'(NUM_REGS - 1));
  assign w_idle_req = (r_state == S_IDLE) && switch_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    rf_rd_addr    = '0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = '0;
    rf_wr_data    = '0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    w_seq_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (switch_req && !w_bad && !w_same)
          w_next_state = r_active_valid ? S_SAVE : S_RESTORE;
      end
      S_SAVE: begin
        rf_rd_addr = r_k;
        if (w_last) w_next_state = S_RESTORE;
      end
      S_RESTORE: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = r_k;
        rf_wr_data = r_ctx[r_next_slot][r_k];
        if (w_last) w_next_state = S_LOAD_PC;
      end
      S_LOAD_PC: begin
        pc_load       = 1'b1;
        pc_load_value = r_ctx_pc[r_next_slot];
        w_seq_done    = 1'b1;
        w_next_state  = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_k            <= '0;
      r_stall        <= 1'b0;
      r_active_valid <= 1'b0;
      r_active_pid   <= '0;
      r_active_slot  <= '0;
      r_next_pid     <= '0;
      r_next_slot    <= '0;
      r_cur_pc       <= '0;
      r_err          <= 1'b0;
      r_same_done    <= 1'b0;
      r_dropped      <= 1'b0;
      for (int unsigned s = 0; s < NUM_PROC; s++) begin
        r_ctx_pc[s] <= START_PC_BASE + START_PC_STRIDE * 32'(s);
        for (int unsigned k = 0; k < NUM_REGS; k++)
          r_ctx[s][k] <= '0;
      end
    end else begin
      r_stall     <= (w_next_state != S_IDLE);
      r_err       <= w_idle_req && w_bad;
      r_same_done <= w_idle_req && !w_bad && w_same;
      r_dropped   <= (r_state != S_IDLE) && switch_req;

      if (w_idle_req && !w_bad && !w_same) begin
        r_next_pid  <= next_pid;
        r_next_slot <= next_pid[SLOT_W-1:0];
        r_cur_pc    <= cur_pc;
      end

      if (((r_state == S_SAVE) || (r_state == S_RESTORE)) && !w_last)
        r_k <= r_k + 5'd1;
      else
        r_k <= '0;

      if (r_state == S_SAVE) begin
        r_ctx[r_active_slot][r_k] <= rf_rd_data;
        if (w_last) r_ctx_pc[r_active_slot] <= r_cur_pc;
      end

      if (r_state == S_LOAD_PC) begin
        r_active_pid   <= r_next_pid;
        r_active_slot  <= r_next_slot;
        r_active_valid <= 1'b1;
      end
    end
  end

  assign cpu_stall   = r_stall;
  assign active_pid  = r_active_pid;
  assign switch_done = w_seq_done | r_same_done;
  assign err_bad_pid = r_err;
  assign req_dropped = r_dropped;

endmodule

// File: tb/tb_context_switch_unit.sv
// Directed bench for context_switch_unit with a behavioural register file attached.
module tb_context_switch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        switch_req = 1'b0;
  logic [31:0] next_pid = '0;
  logic [31:0] cur_pc = '0;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        cpu_stall, pc_load, switch_done, err_bad_pid, req_dropped;
  logic [31:0] pc_load_value, active_pid;

  context_switch_unit #(
    .NUM_PROC(5), .NUM_REGS(32), .START_PC_BASE(32'h0), .START_PC_STRIDE(32'h100)
  ) dut (
    .clock(clock), .reset(reset), .switch_req(switch_req), .next_pid(next_pid),
    .cur_pc(cur_pc), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .cpu_stall(cpu_stall), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .active_pid(active_pid), .switch_done(switch_done), .err_bad_pid(err_bad_pid),
    .req_dropped(req_dropped)
  );

  always #5 clock = ~clock;

  // Register file model; fill_en loads fill_base+k into every register at once.
  logic [31:0] rf [32];
  logic        fill_en = 1'b0;
  logic [31:0] fill_base = '0;
  assign rf_rd_data = rf[rf_rd_addr];
  always @(posedge clock) begin
    if (fill_en) begin
      for (int k = 0; k < 32; k++) rf[k] <= fill_base + 32'(k);
    end else if (rf_wr_en) begin
      rf[rf_wr_addr] <= rf_wr_data;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  int          obs_stall, obs_save, obs_rd_bad, obs_wr_n, obs_pc_n, obs_done_n;
  int          obs_done_with_pc, obs_drop_n, obs_timeout, obs_exit_done;
  logic [31:0] obs_pc_val;
  logic [4:0]  obs_wr_addr [64];
  logic [31:0] obs_wr_data [64];

  task automatic fill_rf(input logic [31:0] base);
    @(negedge clock); fill_en = 1'b1; fill_base = base;
    @(negedge clock); fill_en = 1'b0;
  endtask

  // Issues one switch request and records what the DUT does until cpu_stall drops.
  // inject_at > 0 raises a second request after that many stalled samples.
  task automatic run_switch(input logic [31:0] pid, input logic [31:0] pc, input int inject_at);
    bit ended = 0;
    obs_stall = 0; obs_save = 0; obs_rd_bad = 0; obs_wr_n = 0; obs_pc_n = 0;
    obs_done_n = 0; obs_done_with_pc = 0; obs_drop_n = 0; obs_pc_val = '0;
    @(negedge clock); switch_req = 1'b1; next_pid = pid; cur_pc = pc;
    @(posedge clock); #1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (!cpu_stall) begin ended = 1; break; end
      obs_stall++;
      if (rf_wr_en) begin
        if (obs_wr_n < 64) begin
          obs_wr_addr[obs_wr_n] = rf_wr_addr; obs_wr_data[obs_wr_n] = rf_wr_data;
        end
        obs_wr_n++;
      end else if (!pc_load) begin
        if (rf_rd_addr != 5'(obs_save)) obs_rd_bad++;
        obs_save++;
      end
      if (pc_load) begin
        obs_pc_n++; obs_pc_val = pc_load_value;
        if (switch_done) obs_done_with_pc++;
      end
      if (switch_done) obs_done_n++;
      if (req_dropped) obs_drop_n++;
      @(negedge clock);
      switch_req = (cyc == inject_at);
      if (cyc == inject_at) begin next_pid = 32'd3; cur_pc = 32'hBAD0_BAD0; end
      @(posedge clock); #1;
    end
    obs_timeout   = ended ? 0 : 1;
    obs_exit_done = switch_done ? 1 : 0;
    @(negedge clock); switch_req = 1'b0;
  endtask

  function automatic int wr_mismatches(input logic [31:0] base, input bit inc);
    int bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (obs_wr_addr[k] !== 5'(k)) bad++;
      if (obs_wr_data[k] !== (inc ? base + 32'(k) : base)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_total++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu_stall); else n_pass++;
    n_total++; if ({pc_load, switch_done, err_bad_pid, req_dropped, rf_wr_en} !== 5'b0)
      $display("FAIL reset_pulses: got %b want 00000", {pc_load, switch_done, err_bad_pid, req_dropped, rf_wr_en}); else n_pass++;
    n_total++; if ({active_pid, pc_load_value, rf_wr_data} !== 96'b0)
      $display("FAIL reset_words: got %h/%h/%h want 0", active_pid, pc_load_value, rf_wr_data); else n_pass++;
    n_total++; if ({rf_rd_addr, rf_wr_addr} !== 10'b0)
      $display("FAIL reset_addrs: got %h/%h want 0", rf_rd_addr, rf_wr_addr); else n_pass++;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_first_switch;
    int bad = 0;
    fill_rf(32'hDEAD_0000);
    run_switch(32'd2, 32'h999, 0);
    n_total++; if (obs_timeout != 0) $display("FAIL first_timeout: got %0d want 0", obs_timeout); else n_pass++;
    n_total++; if (obs_stall != 33) $display("FAIL first_stall: got %0d want 33", obs_stall); else n_pass++;
    n_total++; if (obs_save != 0) $display("FAIL first_reads: got %0d want 0", obs_save); else n_pass++;
    n_total++; if (obs_wr_n != 32) $display("FAIL first_writes: got %0d want 32", obs_wr_n); else n_pass++;
    n_total++; if (wr_mismatches(32'h0, 0) != 0) $display("FAIL first_wr_data: got %0d bad want 0", wr_mismatches(32'h0, 0)); else n_pass++;
    n_total++; if (obs_pc_val !== 32'h200) $display("FAIL first_pc: got %h want 00000200", obs_pc_val); else n_pass++;
    n_total++; if (obs_pc_n != 1 || obs_done_with_pc != 1 || obs_done_n != 1 || obs_exit_done != 0)
      $display("FAIL first_pulses: got pc=%0d done=%0d both=%0d after=%0d want 1/1/1/0", obs_pc_n, obs_done_n, obs_done_with_pc, obs_exit_done); else n_pass++;
    n_total++; if (active_pid !== 32'd2) $display("FAIL first_active: got %0d want 2", active_pid); else n_pass++;
    for (int k = 0; k < 32; k++) if (rf[k] !== 32'h0) bad++;
    n_total++; if (bad != 0) $display("FAIL first_rf_zero: got %0d nonzero want 0", bad); else n_pass++;
  endtask

  task automatic test_save_restore;
    fill_rf(32'h100);
    run_switch(32'd0, 32'h40, 0);
    n_total++; if (obs_stall != 65) $display("FAIL sr_out_stall: got %0d want 65", obs_stall); else n_pass++;
    n_total++; if (obs_save != 32 || obs_rd_bad != 0) $display("FAIL sr_out_reads: got %0d reads %0d bad want 32/0", obs_save, obs_rd_bad); else n_pass++;
    n_total++; if (obs_wr_n != 32 || wr_mismatches(32'h0, 0) != 0) $display("FAIL sr_out_writes: got %0d writes want 32 of zero", obs_wr_n); else n_pass++;
    n_total++; if (obs_pc_val !== 32'h0) $display("FAIL sr_out_pc: got %h want 00000000", obs_pc_val); else n_pass++;
    n_total++; if (active_pid !== 32'd0) $display("FAIL sr_out_active: got %0d want 0", active_pid); else n_pass++;
    fill_rf(32'h5500);
    run_switch(32'd2, 32'h80, 0);
    n_total++; if (obs_stall != 65) $display("FAIL sr_back_stall: got %0d want 65", obs_stall); else n_pass++;
    n_total++; if (obs_wr_n != 32 || wr_mismatches(32'h100, 1) != 0)
      $display("FAIL sr_back_writes: got %0d writes %0d bad want 32/0", obs_wr_n, wr_mismatches(32'h100, 1)); else n_pass++;
    n_total++; if (obs_pc_val !== 32'h40) $display("FAIL sr_back_pc: got %h want 00000040", obs_pc_val); else n_pass++;
    n_total++; if (active_pid !== 32'd2) $display("FAIL sr_back_active: got %0d want 2", active_pid); else n_pass++;
  endtask

  task automatic test_same_pid;
    @(negedge clock); switch_req = 1'b1; next_pid = 32'd2; cur_pc = 32'h777;
    @(posedge clock); #1;
    n_total++; if (switch_done !== 1'b1) $display("FAIL same_done: got %b want 1", switch_done); else n_pass++;
    n_total++; if (cpu_stall !== 1'b0 || rf_wr_en !== 1'b0) $display("FAIL same_quiet: got stall=%b wr=%b want 0/0", cpu_stall, rf_wr_en); else n_pass++;
    @(negedge clock); switch_req = 1'b0;
    @(posedge clock); #1;
    n_total++; if (switch_done !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL same_after: got done=%b stall=%b want 0/0", switch_done, cpu_stall); else n_pass++;
  endtask

  task automatic test_bad_pid;
    logic [31:0] bad_ids [2] = '{32'd7, 32'd5};
    foreach (bad_ids[i]) begin
      @(negedge clock); switch_req = 1'b1; next_pid = bad_ids[i]; cur_pc = 32'h123;
      @(posedge clock); #1;
      n_total++; if (err_bad_pid !== 1'b1 || cpu_stall !== 1'b0 || switch_done !== 1'b0)
        $display("FAIL bad_pid_%0d: got err=%b stall=%b done=%b want 1/0/0", bad_ids[i], err_bad_pid, cpu_stall, switch_done); else n_pass++;
      @(negedge clock); switch_req = 1'b0;
      @(posedge clock); #1;
      n_total++; if (err_bad_pid !== 1'b0 || active_pid !== 32'd2)
        $display("FAIL bad_pid_after_%0d: got err=%b active=%0d want 0/2", bad_ids[i], err_bad_pid, active_pid); else n_pass++;
    end
  endtask

  task automatic test_dropped_req;
    run_switch(32'd1, 32'h300, 6);
    n_total++; if (obs_drop_n != 1) $display("FAIL drop_pulse: got %0d want 1", obs_drop_n); else n_pass++;
    n_total++; if (obs_stall != 65 || obs_save != 32 || obs_rd_bad != 0)
      $display("FAIL drop_seq: got stall=%0d reads=%0d bad=%0d want 65/32/0", obs_stall, obs_save, obs_rd_bad); else n_pass++;
    n_total++; if (obs_pc_val !== 32'h100 || active_pid !== 32'd1)
      $display("FAIL drop_dest: got pc=%h active=%0d want 00000100/1", obs_pc_val, active_pid); else n_pass++;
    run_switch(32'd2, 32'h500, 0);
    n_total++; if (obs_wr_n != 32 || wr_mismatches(32'h100, 1) != 0)
      $display("FAIL drop_saved_regs: got %0d writes %0d bad want 32/0", obs_wr_n, wr_mismatches(32'h100, 1)); else n_pass++;
    n_total++; if (obs_pc_val !== 32'h300) $display("FAIL drop_saved_pc: got %h want 00000300", obs_pc_val); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    @(negedge clock); switch_req = 1'b1; next_pid = 32'd3; cur_pc = 32'h111;
    @(posedge clock); #1;
    for (int cyc = 1; cyc < 43; cyc++) begin
      if (cpu_stall) seen++;
      @(negedge clock); switch_req = 1'b0;
      @(posedge clock); #1;
    end
    n_total++; if (seen != 42 || rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd10)
      $display("FAIL mid_position: got stalled=%0d wr=%b addr=%0d want 42/1/10", seen, rf_wr_en, rf_wr_addr); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if ({cpu_stall, rf_wr_en, pc_load, switch_done} !== 4'b0 || rf_wr_addr !== 5'd0 || active_pid !== 32'd0)
      $display("FAIL mid_reset_outs: got stall=%b wr=%b addr=%0d active=%0d want 0/0/0/0", cpu_stall, rf_wr_en, rf_wr_addr, active_pid); else n_pass++;
    @(negedge clock); @(negedge clock); reset = 1'b0;
    run_switch(32'd4, 32'h222, 0);
    n_total++; if (obs_stall != 33 || obs_save != 0)
      $display("FAIL mid_next_first: got stall=%0d reads=%0d want 33/0", obs_stall, obs_save); else n_pass++;
    n_total++; if (obs_wr_n != 32 || wr_mismatches(32'h0, 0) != 0)
      $display("FAIL mid_next_writes: got %0d writes want 32 of zero", obs_wr_n); else n_pass++;
    n_total++; if (obs_pc_val !== 32'h400 || active_pid !== 32'd4)
      $display("FAIL mid_next_pc: got pc=%h active=%0d want 00000400/4", obs_pc_val, active_pid); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_first_switch;
    test_save_restore;
    test_same_pid;
    test_bad_pid;
    test_dropped_req;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
